// File: rtl/sj_array_method_responder_pkg.sv
// sj_array_method_responder_pkg: FSM states, method ids and dispatch priority for the array responder
package sj_array_method_responder_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SET, S_GET_RD, S_GET_WB, S_SUM_RUN, S_SUM_WB} state_t;
  localparam int M_CLEAR = 0;
  localparam int M_SET = 1;
  localparam int M_GET = 2;
  localparam int M_SUM = 3;
  localparam int N_METHODS = 4;
  function automatic logic [N_METHODS-1:0] pick(input logic [N_METHODS-1:0] v);
    return v & (~v + N_METHODS'(1));
  endfunction
endpackage

// File: rtl/sj_array_method_responder_req_edge.sv
// sj_array_method_responder_req_edge: req rise detect, pending flag with latched args, busy term
module sj_array_method_responder_req_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         take,
  input  logic         exec,
  input  logic [W-1:0] arg_in,
  output logic [W-1:0] arg_out,
  output logic         valid,
  output logic         busy
);
  logic req_d, primed, pending, rise;
  logic [W-1:0] lat;
  // primed stays low for the first cycle after reset so a req held through reset is not seen as an edge
  assign rise = req & ~req_d & primed;
  assign valid = rise | pending;
  assign arg_out = rise ? arg_in : lat;
  assign busy = valid | exec;
  // req history, pending flag and latched arguments; a newer edge overwrites the latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_d <= 1'b0;
      primed <= 1'b0;
      pending <= 1'b0;
      lat <= '0;
    end else begin
      req_d <= req;
      primed <= 1'b1;
      pending <= valid & ~take;
      lat <= rise ? arg_in : lat;
    end
  end
endmodule

// File: rtl/sj_array_method_responder.sv
// sj_array_method_responder: req/busy/return callee owning an int array with clear/set/get/sum methods
module sj_array_method_responder
  import sj_array_method_responder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic              set_req,
  input  logic [31:0]       set_i,
  input  logic [DATA_W-1:0] set_v,
  output logic              set_busy,
  input  logic              get_req,
  input  logic [31:0]       get_i,
  output logic [DATA_W-1:0] get_return,
  output logic              get_busy,
  input  logic              sum_req,
  input  logic [31:0]       sum_n,
  output logic [DATA_W-1:0] sum_return,
  output logic              sum_busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int AW = 32 + DATA_W;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
  state_t state, state_nx;
  logic [N_METHODS-1:0] req, valid, take, exec, busy;
  logic [AW-1:0] arg_in [N_METHODS];
  logic [AW-1:0] arg_out [N_METHODS];
  logic [AW-1:0] sel;
  logic [31:0] sel_i, idx;
  logic [DATA_W-1:0] val, rd_data, acc;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0] cnt, lim;
  logic [ADDR_W-1:0] rd_addr;
  logic idx_ok;
  assign req = {sum_req, get_req, set_req, clear_req};
  assign {sum_busy, get_busy, set_busy, clear_busy} = busy;
  assign arg_in[M_CLEAR] = '0;
  assign arg_in[M_SET] = {set_i, set_v};
  assign arg_in[M_GET] = {get_i, {DATA_W{1'b0}}};
  assign arg_in[M_SUM] = {sum_n, {DATA_W{1'b0}}};
  assign exec = {state == S_SUM_RUN || state == S_SUM_WB, state == S_GET_RD || state == S_GET_WB,
                 state == S_SET, state == S_CLEAR};
  assign take = (state == S_IDLE) ? pick(valid) : '0;
  assign sel = take[M_SET] ? arg_out[M_SET] : take[M_GET] ? arg_out[M_GET] :
               take[M_SUM] ? arg_out[M_SUM] : arg_out[M_CLEAR];
  assign sel_i = sel[AW-1:DATA_W];
  assign idx_ok = ~|idx[31:ADDR_W];
  assign rd_addr = (state == S_SUM_RUN) ? cnt[ADDR_W-1:0] : idx[ADDR_W-1:0];
  for (genvar g = 0; g < N_METHODS; g++) begin : g_edge
    sj_array_method_responder_req_edge #(.W(AW)) u_edge (
      .clk(clk), .reset(reset), .req(req[g]), .take(take[g]), .exec(exec[g]),
      .arg_in(arg_in[g]), .arg_out(arg_out[g]), .valid(valid[g]), .busy(busy[g])
    );
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  end
  // next state: dispatch from idle by priority, sweep counters bound clear and sum
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    state_nx = take[M_CLEAR] ? S_CLEAR : take[M_SET] ? S_SET :
                            take[M_GET] ? S_GET_RD : take[M_SUM] ? S_SUM_RUN : S_IDLE;
      S_CLEAR:   state_nx = (cnt == FULL) ? S_IDLE : S_CLEAR;
      S_SET:     state_nx = S_IDLE;
      S_GET_RD:  state_nx = S_GET_WB;
      S_GET_WB:  state_nx = S_IDLE;
      S_SUM_RUN: state_nx = (cnt == lim) ? S_SUM_WB : S_SUM_RUN;
      S_SUM_WB:  state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end
  // array storage; clear sweeps one entry per cycle, out-of-range set writes nothing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      if (state == S_CLEAR && !cnt[ADDR_W]) mem[cnt[ADDR_W-1:0]] <= '0;
      if (state == S_SET && idx_ok) mem[idx[ADDR_W-1:0]] <= val;
    end
  end
  // argument capture on dispatch, sweep counter, accumulator one read behind the address, returns
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
      val <= '0;
      cnt <= '0;
      lim <= '0;
      acc <= '0;
      get_return <= '0;
      sum_return <= '0;
    end else begin
      if (|take) begin
        idx <= sel_i;
        val <= sel[DATA_W-1:0];
        cnt <= '0;
        acc <= '0;
        lim <= |sel_i[31:ADDR_W] ? FULL : {1'b0, sel_i[ADDR_W-1:0]};
      end
      if (state == S_CLEAR || state == S_SUM_RUN) cnt <= cnt + (ADDR_W+1)'(1);
      if (state == S_SUM_RUN && cnt != '0) acc <= acc + rd_data;
      if (state == S_GET_WB) get_return <= idx_ok ? rd_data : '0;
      if (state == S_SUM_WB) sum_return <= acc;
    end
  end
endmodule

// File: tb/tb_sj_array_method_responder.sv
// tb_sj_array_method_responder: table, corner-case and random checks against an array model
module tb_sj_array_method_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = '0;
  logic [31:0] set_i = '0, set_v = '0, get_i = '0, sum_n = '0;
  logic [31:0] get_return, sum_return;
  logic clear_busy, set_busy, get_busy, sum_busy;
  logic [3:0] busy;
  int total = 0;
  int bad = 0;
  logic [31:0] mm [16];
  typedef struct {
    int op;
    logic [31:0] a;
    logic [31:0] v;
    logic [31:0] ret;
    int lat;
  } vec_t;
  vec_t tbl [11];
  assign busy = {sum_busy, get_busy, set_busy, clear_busy};
  always #5 clk = ~clk;
  sj_array_method_responder dut (
    .clk(clk), .reset(reset),
    .clear_req(req[0]), .clear_busy(clear_busy),
    .set_req(req[1]), .set_i(set_i), .set_v(set_v), .set_busy(set_busy),
    .get_req(req[2]), .get_i(get_i), .get_return(get_return), .get_busy(get_busy),
    .sum_req(req[3]), .sum_n(sum_n), .sum_return(sum_return), .sum_busy(sum_busy)
  );
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // op: 0 clear, 1 set(a,v), 2 get(a), 3 sum(a)
  task automatic model_op(input int op, input logic [31:0] a, input logic [31:0] v,
                          output logic [31:0] ret, output int lat);
    int n;
    ret = 0;
    case (op)
      0: begin foreach (mm[k]) mm[k] = 0; lat = 18; end
      1: begin if (a < 16) mm[a[3:0]] = v; lat = 2; end
      2: begin ret = (a < 16) ? mm[a[3:0]] : 32'd0; lat = 3; end
      default: begin
        n = (a > 16) ? 16 : int'(a);
        for (int k = 0; k < n; k++) ret += mm[k];
        lat = n + 3;
      end
    endcase
  endtask
  task automatic invoke(input int op, input logic [31:0] a, input logic [31:0] v,
                        output logic [31:0] ret, output int lat);
    @(posedge clk);
    #1;
    case (op)
      1: begin set_i = a; set_v = v; end
      2: get_i = a;
      3: sum_n = a;
      default: ;
    endcase
    req[op] = 1'b1;
    lat = 0;
    @(negedge clk);
    check("busy_at_edge", 32'(busy[op]), 32'd1);
    while (busy[op] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    ret = (op == 2) ? get_return : sum_return;
    req[op] = 1'b0;
  endtask
  task automatic run(input int op, input logic [31:0] a, input logic [31:0] v, input string name);
    logic [31:0] er, gr;
    int el, gl;
    model_op(op, a, v, er, el);
    invoke(op, a, v, gr, gl);
    check({name, "_lat"}, gl, el);
    if (op >= 2) check({name, "_ret"}, gr, er);
  endtask
  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: bench still running after %0d cycles, required to finish", 50000);
    $fatal(1);
  end
  initial begin
    logic [31:0] r, er;
    int l, el, stuck;
    int t_fall [4];
    tbl[0]  = '{0, 32'd0, 32'd0, 32'd0, 18};
    tbl[1]  = '{1, 32'd3, 32'h55, 32'd0, 2};
    tbl[2]  = '{2, 32'd3, 32'd0, 32'h55, 3};
    tbl[3]  = '{2, 32'd16, 32'd0, 32'd0, 3};
    tbl[4]  = '{1, 32'hFFFF_FFFF, 32'd9, 32'd0, 2};
    tbl[5]  = '{2, 32'd15, 32'd0, 32'd0, 3};
    tbl[6]  = '{1, 32'd0, 32'h7FFF_FFFF, 32'd0, 2};
    tbl[7]  = '{1, 32'd1, 32'd2, 32'd0, 2};
    tbl[8]  = '{3, 32'd2, 32'd0, 32'h8000_0001, 5};
    tbl[9]  = '{3, 32'd0, 32'd0, 32'd0, 3};
    tbl[10] = '{3, 32'd1, 32'd0, 32'h7FFF_FFFF, 4};
    foreach (mm[k]) mm[k] = 0;
    repeat (8) @(posedge clk);
    #1;
    check("busy_in_reset", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_get_return", get_return, 32'd0);
    check("reset_sum_return", sum_return, 32'd0);
    foreach (tbl[i]) begin
      model_op(tbl[i].op, tbl[i].a, tbl[i].v, er, el);
      invoke(tbl[i].op, tbl[i].a, tbl[i].v, r, l);
      check($sformatf("tbl%0d_lat", i), l, tbl[i].lat);
      if (tbl[i].op >= 2) check($sformatf("tbl%0d_ret", i), r, tbl[i].ret);
    end
    for (int i = 0; i < 16; i++) run(1, i, i + 1, "fill_set");
    invoke(3, 32'd16, 32'd0, r, l);
    check("sum16_ret", r, 32'd136);
    check("sum16_lat", l, 32'd19);
    invoke(3, 32'd40, 32'd0, r, l);
    check("sum40_ret", r, 32'd136);
    check("sum40_lat", l, 32'd19);
    @(posedge clk);
    #1;
    set_i = 5;
    set_v = 32'hAB;
    get_i = 5;
    sum_n = 16;
    req = 4'hF;
    @(negedge clk);
    check("all_busy_at_edge", 32'(busy), 32'hF);
    foreach (t_fall[k]) t_fall[k] = -1;
    for (int c = 1; c <= 200 && busy != 0; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (t_fall[k] < 0 && !busy[k]) t_fall[k] = c;
    end
    check("all_done", 32'(busy), 32'd0);
    check("all_clear_lat", t_fall[0], 32'd18);
    check("all_order", 32'(t_fall[0] < t_fall[1] && t_fall[1] < t_fall[2] && t_fall[2] < t_fall[3]), 32'd1);
    check("all_get_ret", get_return, 32'hAB);
    check("all_sum_ret", sum_return, 32'hAB);
    req = '0;
    model_op(0, 0, 0, er, el);
    model_op(1, 5, 32'hAB, er, el);
    @(posedge clk);
    #1;
    sum_n = 16;
    req[3] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("busy_reset_mid_sum", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    foreach (mm[k]) mm[k] = 0;
    stuck = 0;
    repeat (25) begin
      @(negedge clk);
      if (busy != 0) stuck++;
    end
    check("no_replay_busy_cycles", stuck, 32'd0);
    check("no_replay_sum_ret", sum_return, 32'd0);
    req[3] = 1'b0;
    run(1, 2, 7, "post_reset_set");
    run(3, 16, 0, "post_reset_sum");
    for (int i = 0; i < 40; i++) begin
      int sel, op;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      op = (sel == 0) ? 0 : (sel < 5) ? 1 : (sel < 8) ? 2 : 3;
      a = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 18);
      run(op, a, $urandom, $sformatf("rand%0d_op%0d", i, op));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("TEST SUCCESS");
    $finish;
  end
endmodule
